// File: rtl/mux_lut_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : mux_lut_pkg
// Description : Shared types, preset selector encodings and a preset
//               truth-table generator for the mux_lut_array block.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package mux_lut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam logic [1:0] PRESET_AND = 2'b00;
  localparam logic [1:0] PRESET_OR  = 2'b01;
  localparam logic [1:0] PRESET_NOR = 2'b10;
  localparam logic [1:0] PRESET_XOR = 2'b11;

  // Widest lane table the generator can produce; callers keep the low 2^K bits.
  localparam int MAX_K  = 8;
  localparam int MAX_TT = 1 << MAX_K;

  // Builds the 2^k-entry table of a preset; entries above 2^k are zero.
  function automatic logic [MAX_TT-1:0] preset_table(input logic [1:0] sel, input int k);
    logic [MAX_TT-1:0] tbl;
    logic [MAX_K-1:0]  idx;
    tbl = '0;
    for (int i = 0; i < MAX_TT; i++) begin
      idx = MAX_K'(i);
      if (i < (1 << k)) begin
        case (sel)
          PRESET_AND: tbl[i] = (i == ((1 << k) - 1));
          PRESET_OR:  tbl[i] = (i != 0);
          PRESET_NOR: tbl[i] = (i == 0);
          default:    tbl[i] = ^idx;
        endcase
      end
    end
    return tbl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_lut_array_mux_n1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : mux_n1
// Description : Single-bit 2^K:1 multiplexer selecting one truth-table entry.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module mux_n1 #(
  parameter int K = 2
) (
  input  logic [(1<<K)-1:0] tbl,
  input  logic [K-1:0]      sel,
  output logic              y
);

  assign y = tbl[sel];

endmodule
`default_nettype wire

// File: rtl/mux_lut_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : mux_lut_array
// Description : CH independent K-input LUT lanes with a shared truth table
//               loaded serially or from presets; one-deep valid/ready output.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module mux_lut_array
  import mux_lut_pkg::*;
#(
  parameter int K  = 2,
  parameter int CH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  input  logic            preset_en,
  input  logic [1:0]      preset_sel,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*K-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH-1:0]   out_data,
  output logic            cfg_busy,
  output logic            cfg_done
);

  localparam int N   = 1 << K;
  localparam int TTW = CH * N;
  localparam int CW  = (TTW > 1) ? $clog2(TTW) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(TTW - 1);
  localparam logic [N-1:0]  AND_LANE = N'(preset_table(PRESET_AND, K));

  state_t          state, next_state;
  logic [TTW-1:0]  tt;
  logic [CW-1:0]   cnt;
  logic [CH-1:0]   lane_res;
  logic [N-1:0]    preset_lane;
  logic            accept;
  logic            load_last;

  assign preset_lane = N'(preset_table(preset_sel, K));
  assign accept      = in_valid && in_ready;
  assign load_last   = (state == ST_LOAD) && cfg_valid && (cnt == LAST_BIT);
  assign out_valid   = (state == ST_HOLD);

  // One mux per lane, each looking at its own slice of the table.
  for (genvar c = 0; c < CH; c++) begin : g_lane
    mux_n1 #(.K(K)) u_mux (
      .tbl (tt[c*N +: N]),
      .sel (in_data[c*K +: K]),
      .y   (lane_res[c])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; configuration requests only take effect in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (cfg_start)   next_state = ST_LOAD;
        else if (accept) next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready && !accept) next_state = ST_IDLE;
      end
      ST_LOAD: begin
        if (load_last) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready = 1'b0;
    cfg_busy = 1'b0;
    case (state)
      ST_IDLE: in_ready = !cfg_start && !preset_en;
      ST_HOLD: in_ready = out_ready;
      ST_LOAD: cfg_busy = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Truth table, load counter, result register and load-complete pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt       <= {CH{AND_LANE}};
      cnt      <= '0;
      out_data <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= load_last;
      if (accept) out_data <= lane_res;
      if (state == ST_IDLE && cfg_start) begin
        cnt <= '0;
      end else if (state == ST_IDLE && preset_en) begin
        tt <= {CH{preset_lane}};
      end
      if (state == ST_LOAD && cfg_valid) begin
        tt[cnt] <= cfg_bit;
        if (cnt != LAST_BIT) cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_lut_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_mux_lut_array
// Description : Directed vector bench for mux_lut_array (K=2, CH=4).
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mux_lut_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_start, cfg_valid, cfg_bit, preset_en;
  logic [1:0] preset_sel;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data;
  logic [3:0] out_data;
  logic       cfg_busy, cfg_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       pre;
    logic [1:0] sel;
    logic [7:0] din;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [11];

  mux_lut_array #(.K(2), .CH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_bit    (cfg_bit),
    .preset_en  (preset_en),
    .preset_sel (preset_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_preset(input logic [1:0] sel);
    preset_en  = 1'b1;
    preset_sel = sel;
    #1 check("preset in_ready low", in_ready, 0);
    @(negedge clk);
    preset_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] din, input logic [3:0] exp, input string tag);
    in_valid  = 1'b1;
    in_data   = din;
    out_ready = 1'b1;
    #1 check({tag, " in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " out_data"}, out_data, exp);
    @(negedge clk);
    check({tag, " drained"}, out_valid, 0);
  endtask

  task automatic load_tt(input logic [15:0] pat, input logic [31:0] gaps, input int ncyc,
                         input logic with_preset, input string tag);
    int bitn, busy_cnt, done_cnt, rdy_cnt;
    bitn = 0; busy_cnt = 0; done_cnt = 0; rdy_cnt = 0;
    cfg_start  = 1'b1;
    preset_en  = with_preset;
    preset_sel = 2'b11;
    @(negedge clk);
    cfg_start = 1'b0;
    preset_en = 1'b0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      busy_cnt += int'(cfg_busy);
      done_cnt += int'(cfg_done);
      rdy_cnt  += int'(in_ready);
      if (gaps[cyc]) begin
        cfg_valid = 1'b0;
      end else begin
        cfg_valid = 1'b1;
        cfg_bit   = pat[bitn];
        bitn++;
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    check({tag, " done pulse"}, cfg_done, 1);
    for (int cyc = 0; cyc < 3; cyc++) begin
      busy_cnt += int'(cfg_busy);
      done_cnt += int'(cfg_done);
      @(negedge clk);
    end
    check({tag, " busy cycles"}, busy_cnt, ncyc);
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " in_ready in load"}, rdy_cnt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_seen;
    vecs[0]  = '{1'b0, 2'b00, 8'hFF, 4'hF};
    vecs[1]  = '{1'b0, 2'b00, 8'h55, 4'h0};
    vecs[2]  = '{1'b0, 2'b00, 8'hCC, 4'hA};
    vecs[3]  = '{1'b1, 2'b11, 8'hE4, 4'h6};
    vecs[4]  = '{1'b0, 2'b11, 8'hFF, 4'h0};
    vecs[5]  = '{1'b0, 2'b11, 8'h55, 4'hF};
    vecs[6]  = '{1'b1, 2'b01, 8'hE4, 4'hE};
    vecs[7]  = '{1'b0, 2'b01, 8'h00, 4'h0};
    vecs[8]  = '{1'b1, 2'b10, 8'hE4, 4'h1};
    vecs[9]  = '{1'b0, 2'b10, 8'h00, 4'hF};
    vecs[10] = '{1'b1, 2'b00, 8'hE4, 4'h8};

    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    preset_en = 1'b0; preset_sel = 2'b00; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset cfg_busy", cfg_busy, 0);
    check("reset cfg_done", cfg_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Preset and operand vectors.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].pre) do_preset(vecs[i].sel);
      send(vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Serial load with three idle gaps, then evaluate.
    load_tt(16'h9E87, 32'h0000_4208, 19, 1'b0, "load9E87");
    send(8'hE4, 4'b1101, "after load");

    // Back-pressure: result holds, second operand waits.
    do_preset(2'b00);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    @(negedge clk);
    in_data = 8'h00;
    #1 check("bp in_ready low", in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp out_valid", out_valid, 1);
      check("bp out_data held", out_data, 4'hF);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp second out_valid", out_valid, 1);
    check("bp second out_data", out_data, 4'h0);
    @(negedge clk);
    check("bp drained", out_valid, 0);

    // Load aborted by reset after five bits.
    do_preset(2'b11);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1 check("abort busy cleared", cfg_busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      done_seen += int'(cfg_done);
      @(negedge clk);
    end
    check("abort no cfg_done", done_seen, 0);
    send(8'hFF, 4'hF, "abort AND restored");

    // cfg_start while a result is pending is ignored.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    @(negedge clk);
    in_valid  = 1'b0;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check("hold cfg_start busy", cfg_busy, 0);
    check("hold cfg_start out_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("hold released", out_valid, 0);

    // cfg_start wins over a simultaneous preset.
    load_tt(16'h1E86, 32'h0, 16, 1'b1, "start+preset");
    send(8'hFF, 4'b0110, "start+preset result");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
